// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller for the 5-stage core: load-use stalls, taken-branch
// flushes and multi-cycle mult/div occupancy of EX, plus saturating perf counters.
module hazard_sequencer #(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic             branch_taken,
  input  logic             muldiv_start,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_hold,
  output logic             muldiv_done,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {StRun, StBusy} state_e;

  // Value loaded on mult/div start; the final EX cycle is the one seen with cnt == 1.
  localparam logic [3:0]       CntLoad = 4'(MULDIV_LAT - 1);
  localparam logic [CNT_W-1:0] CntOne  = 1;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use;

  // Load in EX whose destination feeds a source of the ID instruction; $0 never stalls.
  always_comb begin
    load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
               ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
  end

  // Next-state and Mealy control outputs; defaults also hold while reset is asserted.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    id_ex_hold   = 1'b0;
    muldiv_done  = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    if (rst_n) begin
      unique case (state_q)
        StRun: begin
          if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (muldiv_start) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_hold  = 1'b1;
            state_d     = StBusy;
            cnt_d       = CntLoad;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        StBusy: begin
          if (cnt_q > 4'd1) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_hold  = 1'b1;
            cnt_d       = cnt_q - 4'd1;
          end else begin
            // Last EX cycle: the following instruction may still hit a load-use hazard.
            muldiv_done = 1'b1;
            if (load_use) begin
              pc_write     = 1'b0;
              if_id_write  = 1'b0;
              id_ex_bubble = 1'b1;
            end
            state_d = StRun;
            cnt_d   = 4'd0;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (if_id_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  // State, occupancy counter and perf counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign busy        = (state_q == StBusy);
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_hazard_sequencer;

  localparam int unsigned Lat = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  if_id_rs, if_id_rt, id_ex_rt;
  logic        if_id_uses_rt, id_ex_mem_read, branch_taken, muldiv_start;

  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, muldiv_done, busy;
  logic [15:0] stall_count, flush_count;
  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_id_ex_hold;
  logic        s_muldiv_done, s_busy;
  logic [3:0]  s_stall_count, s_flush_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.MULDIV_LAT(Lat), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rt(if_id_uses_rt), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .branch_taken(branch_taken), .muldiv_start(muldiv_start), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .id_ex_hold(id_ex_hold), .muldiv_done(muldiv_done), .busy(busy),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // Narrow-counter copy on the same inputs, for saturation.
  hazard_sequencer #(.MULDIV_LAT(Lat), .CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rt(if_id_uses_rt), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .branch_taken(branch_taken), .muldiv_start(muldiv_start), .pc_write(s_pc_write),
    .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble),
    .id_ex_hold(s_id_ex_hold), .muldiv_done(s_muldiv_done), .busy(s_busy),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_done_cyc: EX cycles of the current mult/div already completed (0 = none in flight).
  int   m_done_cyc = 0;
  int   m_stalls   = 0;
  int   m_flushes  = 0;
  logic lu, e_pc, e_fl, e_bub, e_hold, e_done, e_busy;

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  always @(negedge clk) begin
    lu = id_ex_mem_read && (id_ex_rt != 0) &&
         ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
    e_pc = 1'b1; e_fl = 1'b0; e_bub = 1'b0; e_hold = 1'b0; e_done = 1'b0;
    if (!rst_n) begin
      m_done_cyc = 0;
      m_stalls   = 0;
      m_flushes  = 0;
    end else if (m_done_cyc != 0) begin
      if (m_done_cyc + 1 < Lat) begin
        e_pc = 1'b0; e_hold = 1'b1;
      end else begin
        e_done = 1'b1;
        if (lu) begin e_pc = 1'b0; e_bub = 1'b1; end
      end
    end else if (branch_taken) begin
      e_fl = 1'b1; e_bub = 1'b1;
    end else if (muldiv_start) begin
      e_pc = 1'b0; e_hold = 1'b1;
    end else if (lu) begin
      e_pc = 1'b0; e_bub = 1'b1;
    end
    e_busy = (m_done_cyc != 0);

    check("pc_write", int'(pc_write), int'(e_pc));
    check("if_id_write", int'(if_id_write), int'(e_pc));
    check("if_id_flush", int'(if_id_flush), int'(e_fl));
    check("id_ex_bubble", int'(id_ex_bubble), int'(e_bub));
    check("id_ex_hold", int'(id_ex_hold), int'(e_hold));
    check("muldiv_done", int'(muldiv_done), int'(e_done));
    check("busy", int'(busy), int'(e_busy));
    check("stall_count", int'(stall_count), sat(m_stalls, 65535));
    check("flush_count", int'(flush_count), sat(m_flushes, 65535));
    check("small_pc_write", int'(s_pc_write), int'(e_pc));
    check("small_id_ex_hold", int'(s_id_ex_hold), int'(e_hold));
    check("small_stall_count", int'(s_stall_count), sat(m_stalls, 15));
    check("small_flush_count", int'(s_flush_count), sat(m_flushes, 15));
    check("hold_and_bubble", int'(id_ex_hold && id_ex_bubble), 0);

    if (rst_n) begin
      if (!e_pc) m_stalls++;
      if (e_fl) m_flushes++;
      if (m_done_cyc != 0) m_done_cyc = (m_done_cyc + 1 < Lat) ? m_done_cyc + 1 : 0;
      else if (!branch_taken && muldiv_start) m_done_cyc = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic mr, input logic [4:0] xrt, input logic br, input logic md);
    @(posedge clk);
    #1;
    if_id_rs = rs; if_id_rt = rt; if_id_uses_rt = uses;
    id_ex_mem_read = mr; id_ex_rt = xrt; branch_taken = br; muldiv_start = md;
  endtask

  task automatic idle();
    drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic md_prev;
    rst_n = 1'b0;
    if_id_rs = '0; if_id_rt = '0; if_id_uses_rt = 1'b0;
    id_ex_mem_read = 1'b0; id_ex_rt = '0; branch_taken = 1'b0; muldiv_start = 1'b0;
    #3;
    check("reset_pc_write", int'(pc_write), 1);
    check("reset_stall_count", int'(stall_count), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // lw $5 in EX, add using $5 in ID
    drive(5'd5, 5'd3, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    #2;
    check("lu_pc_write", int'(pc_write), 0);
    check("lu_bubble", int'(id_ex_bubble), 1);
    idle(); #2;
    check("lu_stall_count", int'(stall_count), 1);

    // $0 destination never stalls
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0); #2;
    check("r0_no_stall", int'(pc_write), 1);
    // rt match without rt use
    drive(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0); #2;
    check("rt_unused_no_stall", int'(pc_write), 1);
    drive(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0); #2;
    check("rt_used_stall", int'(pc_write), 0);
    idle(); #2;
    check("rt_stall_count", int'(stall_count), 2);

    // mult/div held 4 cycles
    for (int i = 0; i < 3; i++) begin
      drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1); #2;
      check("md_stall", int'(pc_write), 0);
      check("md_hold", int'(id_ex_hold), 1);
    end
    drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1); #2;
    check("md_done", int'(muldiv_done), 1);
    check("md_done_pc_write", int'(pc_write), 1);
    idle(); #2;
    check("md_back_to_run", int'(busy), 0);
    check("md_stall_count", int'(stall_count), 5);

    // branch beats load-use
    drive(5'd5, 5'd3, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); #2;
    check("br_flush", int'(if_id_flush), 1);
    check("br_bubble", int'(id_ex_bubble), 1);
    check("br_pc_write", int'(pc_write), 1);
    idle(); #2;
    check("br_flush_count", int'(flush_count), 1);
    check("br_stall_count", int'(stall_count), 5);

    // 20 load-use stalls
    repeat (20) drive(5'd9, 5'd3, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    idle(); #2;
    check("sat_small", int'(s_stall_count), 15);
    check("sat_wide", int'(stall_count), 25);

    // reset while BUSY with cnt == 2
    drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_pc_write", int'(pc_write), 1);
    check("rst_hold", int'(id_ex_hold), 0);
    check("rst_stall_count", int'(stall_count), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    muldiv_start = 1'b0;
    idle(); #2;
    check("rst_stays_run", int'(busy), 0);
    check("rst_run_pc_write", int'(pc_write), 1);

    // randomized traffic
    md_prev = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst_n          = ($urandom_range(0, 299) != 0);
      if_id_rs       = 5'($urandom_range(0, 3));
      if_id_rt       = 5'($urandom_range(0, 3));
      if_id_uses_rt  = 1'($urandom);
      id_ex_mem_read = ($urandom_range(0, 2) != 0);
      id_ex_rt       = 5'($urandom_range(0, 3));
      branch_taken   = ($urandom_range(0, 7) == 0);
      muldiv_start   = md_prev ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      md_prev        = muldiv_start;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
